// File: rtl/sram_axi_bridge_if.sv
// AXI master bundle for the SRAM-to-AXI bridge.
// Single-beat only: no burst, no response codes.
interface sram_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]          arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [3:0]          rid;
    logic [DATA_W-1:0]   rdata;
    logic                rvalid;
    logic                rready;
    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [3:0]          wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst,
        output awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst,
        input  arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst,
        input  awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Merges the CPU instruction and data SRAM-like ports onto one
// single-beat AXI master, one transaction in flight, data port first.
module sram_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_wstrb,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    sram_axi_bridge_if.master   axi
);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR, WR_RESP
    } state_t;

    state_t                state;
    logic                  owner;
    logic [ADDR_W-1:0]     addr_q;
    logic [1:0]            size_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic                  arvalid_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  rready_q;
    logic                  bready_q;

    logic idle;
    logic r_done;
    logic aw_ok;
    logic w_ok;
    logic unused_rid;

    assign idle   = (state == IDLE);
    assign r_done = (state == RD_DATA) && axi.rvalid;
    // A channel counts as done once its valid has dropped or is taken now.
    assign aw_ok  = !awvalid_q || axi.awready;
    assign w_ok   = !wvalid_q || axi.wready;

    assign data_addr_ok = !reset && idle && data_req;
    assign inst_addr_ok = !reset && idle && !data_req && inst_req;
    assign inst_data_ok = !reset && r_done && !owner;
    assign data_data_ok = !reset && ((r_done && owner) ||
                          ((state == WR_RESP) && axi.bvalid));
    assign inst_rdata   = axi.rdata;
    assign data_rdata   = axi.rdata;
    assign unused_rid   = ^axi.rid;

    assign axi.arid    = {3'b000, owner};
    assign axi.araddr  = addr_q;
    assign axi.arlen   = '0;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;
    assign axi.awid    = 4'd1;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = '0;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = '0;
    assign axi.awcache = '0;
    assign axi.awprot  = '0;
    assign axi.awvalid = awvalid_q;
    assign axi.wid     = 4'd1;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rready_q  <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (data_req) begin
                        addr_q  <= data_addr;
                        size_q  <= data_size;
                        wdata_q <= data_wdata;
                        wstrb_q <= data_wstrb;
                        owner   <= 1'b1;
                        if (data_wr) begin
                            state     <= WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state     <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end else if (inst_req) begin
                        addr_q    <= inst_addr;
                        size_q    <= 2'd2;
                        wdata_q   <= '0;
                        wstrb_q   <= '0;
                        owner     <= 1'b0;
                        state     <= RD_ADDR;
                        arvalid_q <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (axi.rvalid) begin
                        rready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                WR: begin
                    if (axi.awready) awvalid_q <= 1'b0;
                    if (axi.wready) wvalid_q <= 1'b0;
                    if (aw_ok && w_ok) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: latency-programmable AXI slave,
// scoreboard of expected AXI requests and SRAM-side responses.
module tb_sram_axi_bridge;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    sram_axi_bridge_if ax ();

    sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .axi          (ax)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dport;
        logic        wr;
        logic [31:0] rdata;
    } rsp_t;
    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  id;
    } ar_t;
    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
    } w_t;

    rsp_t sb[$];
    ar_t  arq[$];
    ar_t  awq[$];
    w_t   wq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_iacc = 0;
    int n_dacc = 0;
    int n_iok = 0;
    int n_dok = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (a == 32'h1FC0_0000) return 32'h3C1D_0000;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Slave: each ready rises after *_lat cycles of valid; r/b after *_lat.
    int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit rnd = 0;
    logic        r_pend, b_pend, aw_done, w_done;
    logic        aw_done_n, w_done_n;
    logic [31:0] r_val;
    logic [3:0]  r_id;

    assign ax.arready = ax.arvalid && (ar_cnt >= ar_lat);
    assign ax.rvalid  = r_pend && (r_cnt >= r_lat);
    assign ax.rdata   = r_val;
    assign ax.rid     = r_id;
    assign ax.awready = ax.awvalid && (aw_cnt >= aw_lat);
    assign ax.wready  = ax.wvalid && (w_cnt >= w_lat);
    assign ax.bvalid  = b_pend && (b_cnt >= b_lat);
    assign aw_done_n  = aw_done | (ax.awvalid & ax.awready);
    assign w_done_n   = w_done | (ax.wvalid & ax.wready);

    always @(posedge clk) begin
        if (reset) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0;
            w_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0;
            aw_done <= 1'b0; w_done <= 1'b0;
            r_val <= '0; r_id <= '0;
        end else begin
            ar_cnt <= (ax.arvalid && !ax.arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (ax.awvalid && !ax.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (ax.wvalid && !ax.wready) ? w_cnt + 1 : 0;
            if (ax.arvalid && ax.arready) begin
                r_pend <= 1'b1;
                r_cnt  <= 0;
                r_val  <= rd_model(ax.araddr);
                r_id   <= ax.arid;
            end else if (r_pend) begin
                if (ax.rvalid && ax.rready) r_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
            if (aw_done_n && w_done_n) begin
                b_pend  <= 1'b1;
                b_cnt   <= 0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                aw_done <= aw_done_n;
                w_done  <= w_done_n;
                if (b_pend) begin
                    if (ax.bvalid && ax.bready) b_pend <= 1'b0;
                    else b_cnt <= b_cnt + 1;
                end
            end
        end
    end

    // Monitor: pops scoreboards on handshakes and checks stability.
    rsp_t me;
    ar_t  ma;
    w_t   mw;
    logic p_arv, p_arr, p_wv, p_wr, p_rst;
    logic [31:0] p_araddr, p_wdata;

    always @(negedge clk) begin
        if (inst_addr_ok) n_iacc++;
        if (data_addr_ok) n_dacc++;
        if (inst_data_ok) begin
            if (sb.size() == 0) chk("inst_ok_unexpected", 32'd1, 32'd0);
            else begin
                me = sb.pop_front();
                chk("inst_ok_port", 32'(me.dport), 32'd0);
                chk("inst_rdata", inst_rdata, me.rdata);
                n_iok++;
            end
        end
        if (data_data_ok) begin
            if (sb.size() == 0) chk("data_ok_unexpected", 32'd1, 32'd0);
            else begin
                me = sb.pop_front();
                chk("data_ok_port", 32'(me.dport), 32'd1);
                if (!me.wr) chk("data_rdata", data_rdata, me.rdata);
                n_dok++;
            end
        end
        if (ax.arvalid && ax.arready) begin
            if (arq.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
            else begin
                ma = arq.pop_front();
                chk("araddr", ax.araddr, ma.addr);
                chk("arsize", 32'(ax.arsize), 32'(ma.size));
                chk("arid", 32'(ax.arid), 32'(ma.id));
            end
        end
        if (ax.awvalid && ax.awready) begin
            if (awq.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
            else begin
                ma = awq.pop_front();
                chk("awaddr", ax.awaddr, ma.addr);
                chk("awsize", 32'(ax.awsize), 32'(ma.size));
                chk("awid", 32'(ax.awid), 32'(ma.id));
            end
        end
        if (ax.wvalid && ax.wready) begin
            if (wq.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
            else begin
                mw = wq.pop_front();
                chk("wdata", ax.wdata, mw.d);
                chk("wstrb", 32'(ax.wstrb), 32'(mw.s));
            end
        end
        if (p_arv && !p_arr && !p_rst && !reset) begin
            chk("ar_hold_valid", 32'(ax.arvalid), 32'd1);
            chk("ar_hold_addr", ax.araddr, p_araddr);
        end
        if (p_wv && !p_wr && !p_rst && !reset) begin
            chk("w_hold_valid", 32'(ax.wvalid), 32'd1);
            chk("w_hold_data", ax.wdata, p_wdata);
        end
        p_arv    <= ax.arvalid;
        p_arr    <= ax.arready;
        p_araddr <= ax.araddr;
        p_wv     <= ax.wvalid;
        p_wr     <= ax.wready;
        p_wdata  <= ax.wdata;
        p_rst    <= reset;
    end

    task automatic push_exp(input bit dp, input bit wr,
                            input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws);
        rsp_t r;
        ar_t  x;
        w_t   y;
        x.addr = a;
        x.size = dp ? {1'b0, sz} : 3'd2;
        x.id   = dp ? 4'd1 : 4'd0;
        if (dp && wr) begin
            awq.push_back(x);
            y.d = wd;
            y.s = ws;
            wq.push_back(y);
        end else begin
            arq.push_back(x);
        end
        r.dport = dp;
        r.wr    = dp && wr;
        r.rdata = (dp && wr) ? 32'd0 : rd_model(a);
        sb.push_back(r);
    endtask

    task automatic issue(input bit dp, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, output int waits);
        if (dp) begin
            data_req = 1'b1; data_wr = wr; data_size = sz;
            data_addr = a; data_wdata = wd; data_wstrb = ws;
        end else begin
            inst_req = 1'b1; inst_addr = a;
        end
        waits = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dp ? data_addr_ok : inst_addr_ok) begin
                waits = i;
                break;
            end
        end
        chk("accept_timeout", 32'(waits < 0), 32'd0);
        if (waits >= 0) push_exp(dp, wr, sz, a, wd, ws);
        if (rnd) begin
            ar_lat = $urandom_range(0, 3);
            r_lat  = $urandom_range(0, 3);
        end
        @(posedge clk); #1;
        if (dp) data_req = 1'b0;
        else inst_req = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    int w, dok, iac, nb, sd, so;

    initial begin
        reset = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0;
        data_addr = '0; data_wdata = '0; data_wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        inst_req = 1'b1;
        data_req = 1'b1;
        @(negedge clk);
        chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("rst_valids", 32'({ax.arvalid, ax.awvalid, ax.wvalid}), 32'd0);
        chk("rst_readys", 32'({ax.rready, ax.bready}), 32'd0);
        chk("const_len", 32'({ax.arlen, ax.awlen}), 32'd0);
        chk("const_burst", 32'({ax.arburst, ax.awburst}), 32'h5);
        chk("const_wlast_wid", 32'({ax.wlast, ax.wid}), 32'h11);
        chk("const_attr", 32'({ax.arlock, ax.arcache, ax.arprot,
            ax.awlock, ax.awcache, ax.awprot}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        inst_req = 1'b0;
        data_req = 1'b0;
        @(posedge clk); #1;

        // Single instruction read, cycle-exact.
        issue(1'b0, 1'b0, 2'd2, 32'h1FC0_0000, 32'd0, 4'd0, w);
        chk("t1_accept_cycle", 32'(w), 32'd0);
        @(negedge clk);
        chk("t1_arvalid", 32'(ax.arvalid), 32'd1);
        chk("t1_araddr", ax.araddr, 32'h1FC0_0000);
        chk("t1_arsize", 32'(ax.arsize), 32'd2);
        @(negedge clk);
        chk("t1_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t1_rdata", inst_rdata, 32'h3C1D_0000);
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 2'd2, 32'h1FC0_0004, 32'd0, 4'd0, w);
        chk("t1_next_accept", 32'(w), 32'd0);
        drain();

        // Byte store with awready two cycles ahead of wready.
        w_lat = 2;
        issue(1'b1, 1'b1, 2'd0, 32'h0000_0003, 32'hAA00_0000, 4'b1000, w);
        @(negedge clk);
        chk("bs_c1_valids", 32'({ax.awvalid, ax.wvalid}), 32'h3);
        @(negedge clk);
        chk("bs_c2_valids", 32'({ax.awvalid, ax.wvalid}), 32'h1);
        @(negedge clk);
        chk("bs_c3_wvalid", 32'(ax.wvalid), 32'd1);
        nb = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (data_data_ok) nb++;
        end
        chk("bs_ok_pulses", 32'(nb), 32'd1);
        w_lat = 0;
        drain();

        // Arbitration: data wins, instruction follows data_ok.
        r_lat = 2;
        inst_req = 1'b1;
        inst_addr = 32'h0000_0500;
        sd = n_iacc;
        issue(1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0, 4'd0, w);
        chk("arb_data_first", 32'(w), 32'd0);
        chk("arb_no_inst_acc", 32'(n_iacc - sd), 32'd0);
        dok = -1;
        iac = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (data_data_ok && dok < 0) dok = c;
            if (inst_addr_ok) begin
                iac = c;
                push_exp(1'b0, 1'b0, 2'd2, 32'h0000_0500, 32'd0, 4'd0);
                break;
            end
        end
        @(posedge clk); #1;
        inst_req = 1'b0;
        chk("arb_dok_seen", 32'(dok >= 0), 32'd1);
        chk("arb_inst_after_dok", 32'(iac), 32'(dok + 1));
        r_lat = 0;
        drain();

        // Back-pressure on AR for five cycles.
        ar_lat = 5;
        issue(1'b1, 1'b0, 2'd2, 32'h0000_2000, 32'd0, 4'd0, w);
        inst_req = 1'b1;
        inst_addr = 32'h0000_0600;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_arvalid", 32'(ax.arvalid), 32'd1);
            chk("bp_araddr", ax.araddr, 32'h0000_2000);
            chk("bp_no_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
            chk("bp_no_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        end
        @(negedge clk);
        chk("bp_c6_arvalid", 32'(ax.arvalid), 32'd1);
        @(posedge clk); #1;
        inst_req = 1'b0;
        ar_lat = 0;
        drain();

        // Reset while in RD_DATA, rvalid lands during reset.
        r_lat = 1;
        issue(1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'd0, 4'd0, w);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_rready", 32'(ax.rready), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_mid_no_ok", 32'(inst_data_ok), 32'd0);
        @(negedge clk);
        chk("rst_mid_rready0", 32'(ax.rready), 32'd0);
        chk("rst_mid_arvalid0", 32'(ax.arvalid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        r_lat = 0;
        so = n_iok;
        issue(1'b0, 1'b0, 2'd2, 32'h0000_0080, 32'd0, 4'd0, w);
        chk("rst_fresh_accept", 32'(w), 32'd0);
        drain();
        chk("rst_fresh_ok", 32'(n_iok - so), 32'd1);

        // Eight back-to-back data reads, random latency.
        rnd = 1;
        sd = n_dacc;
        so = n_dok;
        for (int i = 0; i < 8; i++)
            issue(1'b1, 1'b0, 2'd2, 32'h0000_3000 + 32'(i * 4),
                  32'd0, 4'd0, w);
        drain();
        rnd = 0;
        chk("b2b_addr_ok", 32'(n_dacc - sd), 32'd8);
        chk("b2b_data_ok", 32'(n_dok - so), 32'd8);

        chk("end_arq", 32'(arq.size()), 32'd0);
        chk("end_awq", 32'(awq.size()), 32'd0);
        chk("end_wq", 32'(wq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
